// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states,
// and the operation-class helper used by the sequencer and hazard logic.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// E-stage request bundle and HI/LO/hazard results of the multiply/divide unit.
interface md_ctrl_if;

  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_D,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_D,
    output busy, stall_md, hi, lo
  );

endinterface

// File: rtl/md_ctrl_arith.sv
// md_arith: single-cycle combinational product/quotient/remainder for the
// MULT/MULTU/DIV/DIVU ops; latency is modelled separately by md_ctrl.
module md_ctrl_arith
  import md_ctrl_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] s_a, s_b, prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        den_safe, num, den, q_mag, r_mag;
  logic               is_sdiv;

  assign s_a    = {{32{rs_val[31]}}, rs_val};
  assign s_b    = {{32{rt_val[31]}}, rt_val};
  assign prod_s = s_a * s_b;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division runs on magnitudes, then fixes signs: quotient negative
  // when signs differ, remainder follows the dividend. This also yields
  // 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  assign is_sdiv  = (md_op == MD_DIV);
  assign den_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign num      = (is_sdiv && rs_val[31])   ? -rs_val   : rs_val;
  assign den      = (is_sdiv && den_safe[31]) ? -den_safe : den_safe;
  assign q_mag    = num / den;
  assign r_mag    = num % den;

  assign div_zero = ((md_op == MD_DIV) || (md_op == MD_DIVU)) && (rt_val == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_lo = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
        res_hi = rs_val[31] ? -r_mag : r_mag;
      end
      MD_DIVU: begin
        res_lo = q_mag;
        res_hi = r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, models op latency with a
// down-counter, and requests a D-stage stall while the unit is occupied.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_ctrl_if.slave  md
);

  md_state_e   state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo, ar_hi, ar_lo;
  logic        res_dz, ar_dz, req_md, is_div;

  assign req_md = md.start && is_muldiv(md.md_op);
  assign is_div = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);

  md_ctrl_arith u_arith (
    .md_op    (md.md_op),
    .rs_val   (md.rs_val),
    .rt_val   (md.rt_val),
    .res_hi   (ar_hi),
    .res_lo   (ar_lo),
    .div_zero (ar_dz)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_md)       state_nxt = S_BUSY;
      S_BUSY: if (cnt <= 4'd1)  state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    md.busy     = (state == S_BUSY);
    md.stall_md = md.md_use_D && ((state == S_BUSY) || req_md);
  end

  // Datapath: capture operands' result at accept, commit on the last busy edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 4'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_dz <= 1'b0;
      md.hi  <= 32'd0;
      md.lo  <= 32'd0;
    end else if (state == S_IDLE) begin
      if (req_md) begin
        res_hi <= ar_hi;
        res_lo <= ar_lo;
        res_dz <= ar_dz;
        cnt    <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (md.start && md.md_op == MD_MTHI) begin
        md.hi <= md.rs_val;
      end else if (md.start && md.md_op == MD_MTLO) begin
        md.lo <= md.rs_val;
      end
    end else begin
      cnt <= cnt - 4'd1;
      // A divide by zero still spends its cycles but leaves HI/LO untouched.
      if (cnt == 4'd1 && !res_dz) begin
        md.hi <= res_hi;
        md.lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed + randomized bench for md_ctrl against an arithmetic reference model.
module tb_md_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_ctrl_if bus ();

  md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic; HDL '/' and '%' on signed
  // operands already truncate toward zero with remainder taking dividend sign.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          p;
    longint unsigned up;
    case (op)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      3'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      3'd2: if (b != 0) begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
      3'd3: if (b != 0) begin up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Issue one op in the current cycle and follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input bit poke);
    bit          long_op = (op <= 3'd3);
    int          n = (op <= 3'd1) ? MULT_N : DIV_N;
    logic [31:0] old_hi = exp_hi;
    logic [31:0] old_lo = exp_lo;
    bus.start = 1'b1; bus.md_op = op; bus.rs_val = a; bus.rt_val = b; bus.md_use_D = use_d;
    #1;
    check("stall_at_issue", {31'd0, bus.stall_md}, {31'd0, use_d & long_op});
    tick();
    bus.start = 1'b0;
    model_op(op, a, b, exp_hi, exp_lo);
    if (long_op) begin
      for (int i = 1; i <= n; i++) begin
        check("busy_during", {31'd0, bus.busy}, 32'd1);
        check("stall_during", {31'd0, bus.stall_md}, {31'd0, use_d});
        check("hi_hold", bus.hi, old_hi);
        check("lo_hold", bus.lo, old_lo);
        if (poke && i == 2) begin
          bus.start = 1'b1; bus.md_op = 3'd3;
          bus.rs_val = $urandom; bus.rt_val = $urandom_range(1, 1000);
        end
        tick();
        bus.start = 1'b0;
      end
    end
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("stall_after", {31'd0, bus.stall_md}, 32'd0);
    check("hi_after", bus.hi, exp_hi);
    check("lo_after", bus.lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.md_op = 3'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0; bus.md_use_D = 1'b0;
    tick(); tick();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_stall", {31'd0, bus.stall_md}, 32'd0);
    reset = 1'b0;

    // MULT / MULTU with -2 * 3
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    check("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_lit", bus.lo, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    check("multu_hi_lit", bus.hi, 32'h0000_0002);

    // DIV -7 / 2, no D-stage user: stall stays low while busy
    run_op(3'd2, -32'sd7, 32'd2, 1'b0, 1'b0);
    check("div_lo_lit", bus.lo, 32'hFFFF_FFFD);
    check("div_hi_lit", bus.hi, 32'hFFFF_FFFF);

    // DIVU by zero leaves preloaded HI/LO unchanged
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    run_op(3'd3, 32'd7, 32'd0, 1'b1, 1'b0);
    check("divz_hi_lit", bus.hi, 32'h1234_5678);

    // Overflow case and MTHI/MTLO back to back
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0);

    // Start during BUSY is ignored; undefined op is ignored
    run_op(3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1, 1'b1);
    run_op(3'd6, 32'h5555_5555, 32'd9, 1'b1, 1'b0);
    run_op(3'd7, 32'hAAAA_AAAA, 32'd9, 1'b0, 1'b0);

    // Reset in cycle T+4 of a DIV abandons the op
    bus.start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_hi", bus.hi, 32'd0);
    check("rst_mid_lo", bus.lo, 32'd0);
    tick();
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (DIV_N) tick();
    check("no_commit_busy", {31'd0, bus.busy}, 32'd0);
    check("no_commit_hi", bus.hi, 32'd0);
    check("no_commit_lo", bus.lo, 32'd0);

    // Randomized ops, including back-to-back issue and occasional zero divisors
    for (int k = 0; k < 60; k++) begin
      logic [2:0]  op = 3'($urandom_range(0, 7));
      logic [31:0] a  = $urandom;
      logic [31:0] b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
